// File: rtl/async_to_sync_rx.sv
// Receiver from a 4-phase bundled-data micropipeline into the clk domain, with a FWFT FIFO.
// Optional: define ASYNC_RX_PROTO_CHK_EN to build the sticky bundled-data violation checker.
module async_to_sync_rx #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_req,
  input  logic [WIDTH-1:0]         a_data,
  output logic                     a_ack,
  output logic                     s_valid,
  input  logic                     s_ready,
  output logic [WIDTH-1:0]         s_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACK_HI = 1'b1
  } state_t;

  // Request synchronizer
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_req_s;

  // NOTE: sequential state is always updated with non-blocking assignments so every
  // flop samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], a_req};
    end
  end

  assign w_req_s = r_sync[SYNC_STAGES-1];

  // Handshake FSM
  state_t r_state;
  state_t w_state_nxt;
  logic   r_ack;
  logic   w_ack_nxt;
  logic   w_push;
  logic   w_pop;
  logic   w_full;
  logic   w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ack_nxt = 1'b0;
        // A full FIFO withholds the acknowledge; upstream simply waits.
        if (w_req_s && !w_full) begin
          w_push      = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_ACK_HI;
        end
      end
      ST_ACK_HI: begin
        w_ack_nxt = 1'b1;
        if (!w_req_s) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  assign a_ack = r_ack;

  // First-word-fall-through FIFO
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Full uses the registered count only: a same-cycle pop never frees a slot for a push.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && s_ready;

  // NOTE: storage is not reset; the pointers and count define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= a_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign s_valid    = !w_empty;
  assign s_data     = s_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_count = r_count;

`ifdef ASYNC_RX_PROTO_CHK_EN
  logic [WIDTH-1:0] r_hold;
  logic             r_proto_err;

  // Data must not move while the request is still seen high after capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold      <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_hold <= a_data;
      end
      if (r_state == ST_ACK_HI && w_req_s && a_data != r_hold) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_async_to_sync_rx.sv
// Scoreboard bench for async_to_sync_rx: directed handshakes, backpressure, wrap, reset, proto check.
module tb_async_to_sync_rx;

  localparam int WIDTH       = 8;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;

`ifdef ASYNC_RX_PROTO_CHK_EN
  localparam logic EXP_PERR = 1'b1;
`else
  localparam logic EXP_PERR = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   a_req = 1'b0;
  logic [WIDTH-1:0]       a_data = '0;
  logic                   a_ack;
  logic                   s_valid;
  logic                   s_ready = 1'b0;
  logic [WIDTH-1:0]       s_data;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   proto_err;

  int n_vec = 0;
  int n_err = 0;
  logic [WIDTH-1:0] q[$];
  bit track = 1'b0;
  int max_cnt = 0;

  async_to_sync_rx #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_req     (a_req),
    .a_data    (a_data),
    .a_ack     (a_ack),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .fifo_count(fifo_count),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input int max, output int edges);
    edges = 0;
    while (a_ack !== lvl && edges < max) begin
      tick(1);
      edges++;
    end
  endtask

  // Full 4-phase handshake; the word is expected to reach the consumer.
  task automatic send_word(input logic [WIDTH-1:0] d);
    int e;
    a_data = d;
    a_req  = 1'b1;
    q.push_back(d);
    wait_ack(1'b1, 50, e);
    check("ack rise edges", e, 3);
    a_req = 1'b0;
    wait_ack(1'b0, 50, e);
    check("ack fall edges", e, 3);
  endtask

  task automatic drain();
    int k = 0;
    s_ready = 1'b1;
    while (fifo_count != 0 && k < 50) begin
      tick(1);
      k++;
    end
    s_ready = 1'b0;
    check("drain empty", fifo_count, 0);
  endtask

  // Monitor: compare every accepted head word against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_valid && s_ready) begin
        if (q.size() == 0) begin
          check("unexpected pop", 32'(s_data), 32'hFFFF_FFFF);
        end else begin
          check("pop data", 32'(s_data), 32'(q.pop_front()));
        end
      end else if (!s_valid) begin
        check("idle s_data", 32'(s_data), 0);
      end
    end
    if (track && int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
  end

  initial begin
    int e;
    // Reset values
    tick(3);
    check("rst a_ack", a_ack, 0);
    check("rst s_valid", s_valid, 0);
    check("rst s_data", s_data, 0);
    check("rst fifo_count", fifo_count, 0);
    check("rst proto_err", proto_err, 0);
    rst = 1'b0;
    tick(2);

    // Single word, s_valid visible right after the capture edge
    a_data = 8'hA5;
    a_req  = 1'b1;
    q.push_back(8'hA5);
    wait_ack(1'b1, 50, e);
    check("single ack rise edges", e, 3);
    check("single s_valid", s_valid, 1);
    check("single s_data", s_data, 8'hA5);
    check("single count", fifo_count, 1);
    a_req = 1'b0;
    wait_ack(1'b0, 50, e);
    check("single ack fall edges", e, 3);
    s_ready = 1'b1;
    tick(1);
    s_ready = 1'b0;
    check("single s_valid after pop", s_valid, 0);
    check("single s_data after pop", s_data, 0);

    // Fill and backpressure, then pop at full with req_s already high
    for (int i = 1; i <= 4; i++) send_word(8'(i));
    check("fill count", fifo_count, 4);
    a_data = 8'h05;
    a_req  = 1'b1;
    q.push_back(8'h05);
    tick(10);
    check("full stall ack", a_ack, 0);
    check("full stall count", fifo_count, 4);
    s_ready = 1'b1;
    tick(1);
    s_ready = 1'b0;
    check("pop at full count", fifo_count, 3);
    check("pop at full no push", a_ack, 0);
    tick(1);
    check("push after pop ack", a_ack, 1);
    check("push after pop count", fifo_count, 4);
    a_req = 1'b0;
    wait_ack(1'b0, 50, e);
    check("stalled ack fall edges", e, 3);
    drain();
    check("fill scoreboard empty", q.size(), 0);

    // Pointer wrap with a free-running consumer
    s_ready = 1'b1;
    max_cnt = 0;
    track   = 1'b1;
    for (int i = 0; i < 10; i++) send_word(8'h10 + 8'(i * 7));
    tick(4);
    track   = 1'b0;
    s_ready = 1'b0;
    check("wrap max count over 1", max_cnt > 1, 0);
    check("wrap scoreboard empty", q.size(), 0);
    check("wrap final count", fifo_count, 0);

    // Reset while in ACK_HI with a_req held: word is captured again
    a_data = 8'h77;
    a_req  = 1'b1;
    q.push_back(8'h77);
    wait_ack(1'b1, 50, e);
    check("pre-reset ack edges", e, 3);
    rst = 1'b1;
    q.delete();
    tick(1);
    check("mid reset a_ack", a_ack, 0);
    check("mid reset count", fifo_count, 0);
    check("mid reset s_valid", s_valid, 0);
    rst = 1'b0;
    q.push_back(8'h77);
    wait_ack(1'b1, 50, e);
    check("recapture ack edges", e, 3);
    check("recapture count", fifo_count, 1);
    a_req = 1'b0;
    wait_ack(1'b0, 50, e);
    drain();

    // Bundled-data violation during ACK_HI
    a_data = 8'h3C;
    a_req  = 1'b1;
    q.push_back(8'h3C);
    wait_ack(1'b1, 50, e);
    check("proto ack edges", e, 3);
    check("proto clean before change", proto_err, 0);
    a_data = 8'h3D;
    tick(1);
    check("proto_err set", proto_err, EXP_PERR);
    a_data = 8'h3C;
    a_req  = 1'b0;
    wait_ack(1'b0, 50, e);
    tick(3);
    check("proto_err sticky", proto_err, EXP_PERR);
    drain();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("proto_err cleared", proto_err, 0);
    tick(3);

    check("final scoreboard empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
